// File: rtl/hc595_pkg.sv
// Shared types and defaults for the 74HC595 chain controller.
// The FSM state encoding lives here so the top and any monitors agree on it.
package hc595_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 2;
  localparam int DIV_CW    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_e;

endpackage

// File: rtl/hc595_tick_div.sv
// Half-period divider: one-cycle tick every DIV enabled cycles.
// Held at zero while disabled, so every phase restarts cleanly on enable.
module hc595_tick_div
  import hc595_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_CW-1:0] LAST = DIV_CW'(DIV - 1);

  logic [DIV_CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (!en || tick) cnt <= '0;
    else                 cnt <= cnt + DIV_CW'(1);
  end

endmodule

// File: rtl/hc595_ctrl.sv
// Serial driver for a cascade of 74HC595-style shift registers: MSB-first
// shift on srclk, then one rclk pulse to latch. All outputs are registered.
module hc595_ctrl
  import hc595_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser,
  output logic             srclk,
  output logic             rclk,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    bits_q, bits_d;
  logic             ser_d;
  logic             tick;
  logic             div_en;

  assign div_en   = (state_q != IDLE);
  assign in_ready = (state_q == IDLE);

  hc595_tick_div #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (div_en),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    bits_d  = bits_q;
    ser_d   = ser;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SETUP;
        data_d  = in_data;
        bits_d  = CW'(WIDTH);
        ser_d   = in_data[WIDTH-1];
      end
      SETUP: if (tick) state_d = HIGH;
      HIGH: if (tick) begin
        bits_d = bits_q - CW'(1);
        if (bits_q == CW'(1)) begin
          state_d = LATCH;
          ser_d   = 1'b0;
        end else begin
          // ser only moves here, on SETUP entry, so hold time equals setup time
          state_d = SETUP;
          data_d  = data_q << 1;
          ser_d   = data_d[WIDTH-1];
        end
      end
      LATCH: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next state so they align with the state itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      bits_q  <= '0;
      ser     <= 1'b0;
      srclk   <= 1'b0;
      rclk    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      bits_q  <= bits_d;
      ser     <= ser_d;
      srclk   <= (state_d == HIGH);
      rclk    <= (state_d == LATCH);
      busy    <= (state_d != IDLE);
      done    <= (state_q == LATCH) && (state_d == IDLE);
    end
  end

endmodule

// File: doc/hc595_ctrl.md
HC595_CTRL -- requirements
Module: hc595_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bits per transfer (number of cascaded shift-register stages); legal range 1..32.
REQ-002 Parameter DIV, default 2: clk cycles per serial-clock half-period; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  parallel word to shift out, MSB first.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  controller can accept a word.
REQ-008 ser  output  1  serial data to the first stage D input.
REQ-009 srclk  output  1  shift clock to all stages.
REQ-010 rclk  output  1  storage/latch clock to the output register.
REQ-011 busy  output  1  transfer in progress.
REQ-012 done  output  1  single-cycle pulse when a transfer completes.

Function
REQ-013 The block SHALL accept a word when in_valid and in_ready are both high at a rising clk edge (the accept edge), capturing in_data into an internal WIDTH-bit register.
REQ-014 in_ready SHALL be high only in state IDLE; in_valid outside IDLE SHALL be ignored and no data captured.
REQ-015 The FSM SHALL have states IDLE, SETUP, HIGH and LATCH: IDLE->SETUP on accept; SETUP->HIGH after DIV cycles; HIGH->SETUP after DIV cycles while bits remain, else HIGH->LATCH; LATCH->IDLE after DIV cycles.
REQ-016 In SETUP, ser SHALL present the current bit (MSB first, bit WIDTH-1 down to 0) and srclk SHALL be 0; in HIGH, srclk SHALL be 1 and ser SHALL hold the same bit.
REQ-017 ser SHALL change only on the SETUP entry edge, giving DIV cycles of setup and DIV cycles of hold around each srclk rising edge.
REQ-018 In LATCH, rclk SHALL be 1, srclk 0 and ser 0; rclk SHALL be 0 in all other states.
REQ-019 A transfer SHALL produce exactly WIDTH srclk rising edges followed by exactly one rclk high pulse of DIV cycles.
REQ-020 done SHALL be high for exactly the first IDLE cycle after LATCH; the cycle-accurate accept-to-done latency is WIDTH*2*DIV+DIV+1 cycles (35 for defaults).
REQ-021 A new word presented in the done cycle SHALL be accepted in that cycle (back-to-back transfers with no gap cycle).
REQ-022 busy SHALL be high in SETUP, HIGH and LATCH and low in IDLE.
REQ-023 All outputs SHALL be driven directly from flip-flops (no combinational path from inputs to outputs), except in_ready, which is decoded from state only.
REQ-024 The bit counter SHALL be sized ceil(log2(WIDTH+1)) bits and the divider counter 8 bits; neither SHALL wrap during a legal transfer.

Reset
REQ-025 On rst_n low, the block SHALL enter IDLE immediately: ser=0, srclk=0, rclk=0, busy=0, done=0, in_ready=1 after release, and both counters and the data register cleared.
REQ-026 Reset asserted mid-transfer SHALL abort it with no rclk pulse, so the downstream output register keeps its previous value.
REQ-027 The first accept after rst_n deasserts SHALL be possible in the first clk cycle after release.

Structure
REQ-028 A shared package hc595_pkg SHALL hold the FSM state enumeration and the default WIDTH and DIV constants.
REQ-029 The DIV half-period counter SHALL be a sub-module, hc595_tick_div, producing a one-cycle tick every DIV cycles when enabled and restarting from zero on enable assertion.

Verification
REQ-030 WIDTH=8, DIV=2, in_data=0xA5 -> ser per bit 1,0,1,0,0,1,0,1; 8 srclk rising edges at cycles 3,7,...,31 after the accept edge; rclk high in cycles 33-34; done in cycle 35.
REQ-031 Back-to-back: 0x3C, then 0xC3 held valid -> second accept in the done cycle of the first; 16 srclk edges and 2 rclk pulses total; no idle gap.
REQ-032 in_valid toggled while busy with 0xFF -> ignored; the serial stream matches only the accepted word; in_ready stays low until done.
REQ-033 rst_n pulsed low at cycle 10 of a transfer -> all outputs 0 within the reset cycle; no rclk pulse; the next word transfers correctly.
REQ-034 DIV=1, WIDTH=4, in_data=0x9 -> srclk toggles every cycle; ser 1,0,0,1; latency 4*2+1+1=10 cycles.
REQ-035 Chain-model check: hc595_ctrl drives a 4-stage D-flip-flop shift-chain model -> after rclk, latched stage outputs equal the transferred nibble for all 16 values.
